dmem_bus_arbiter: RTL

//  Shares the single data-memory/UART bus behind the LSU between two requesters.

---
 rtl/dmem_bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_bus_arbiter.sv
// Shares the LSU data-memory/UART bus between the core (requester 0) and the
// UART boot/debug DMA (requester 1); zero-latency combinational grant.
module dmem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_CORE_BURST = 4,
    parameter int MAX_LOCK       = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_func3,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner,
    output logic              lock_err
);

    localparam int STARVE_W = $clog2(MAX_CORE_BURST + 1);
    localparam int LOCK_W   = $clog2(MAX_LOCK);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_CORE_BURST);
    localparam logic [LOCK_W-1:0]   LOCK_LAST  = LOCK_W'(MAX_LOCK - 1);

    localparam logic [0:0] ST_ARB      = 1'b0;
    localparam logic [0:0] ST_DMA_LOCK = 1'b1;

    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_CORE = 2'b01;
    localparam logic [1:0] RD_DMA  = 2'b10;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

    logic [0:0]          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [1:0]          rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0]   core_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;

    logic in_lock;
    logic watchdog;
    logic dma_first;
    logic grant_core;
    logic grant_dma;

    // Grants are gated by reset so nothing reaches the bus while reset is held.
    always_comb begin
        in_lock    = (state_q == ST_DMA_LOCK);
        watchdog   = in_lock && (lock_q == LOCK_LAST);
        dma_first  = dma_req && (starve_q == STARVE_MAX);
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        if (reset) begin
            if (in_lock) begin
                grant_dma = dma_req;
            end else if (dma_first) begin
                grant_dma = 1'b1;
            end else if (core_req) begin
                grant_core = 1'b1;
            end else begin
                grant_dma = dma_req;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lock_d   = lock_q;
        if (in_lock) begin
            lock_d = lock_q + 1'b1;
            if (watchdog || !dma_req || (grant_dma && !dma_lock)) begin
                state_d = ST_ARB;
            end
        end else if (grant_dma && dma_lock) begin
            state_d = ST_DMA_LOCK;
            lock_d  = '0;
        end

        if (grant_dma || !dma_req || watchdog) begin
            starve_d = '0;
        end else if (grant_core && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (grant_core && !core_we) begin
            rd_owner_d = RD_CORE;
        end else if (grant_dma && !dma_we) begin
            rd_owner_d = RD_DMA;
        end
    end

    // An asynchronous reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ARB;
            starve_q     <= '0;
            lock_q       <= '0;
            rd_owner_q   <= RD_NONE;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lock_q     <= lock_d;
            rd_owner_q <= rd_owner_d;
            if (rd_owner_q == RD_CORE) begin
                core_rdata_q <= mem_rdata;
            end
            if (rd_owner_q == RD_DMA) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign core_gnt    = grant_core;
    assign core_stall  = core_req & ~grant_core;
    assign core_rvalid = (rd_owner_q == RD_CORE);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;

    assign dma_gnt     = grant_dma;
    assign dma_rvalid  = (rd_owner_q == RD_DMA);
    assign dma_rdata   = dma_rvalid ? mem_rdata : dma_rdata_q;

    assign mem_rd_en   = (grant_core & ~core_we) | (grant_dma & ~dma_we);
    assign mem_wr_en   = (grant_core & core_we) | (grant_dma & dma_we);
    assign mem_addr    = grant_dma ? dma_addr : core_addr;
    assign mem_wdata   = grant_dma ? dma_wdata : core_wdata;
    assign mem_func3   = grant_dma ? FUNC3_WORD : core_func3;

    assign owner       = {grant_dma, grant_core};
    assign lock_err    = watchdog;

endmodule
